// File: rtl/seg_pkg.sv
// Shared definitions for the dot-product result display: FSM state type,
// digit count and active-low seven-segment patterns (bit 0 = a ... bit 6 = g).
package seg_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg_decoder.sv
// BCD digit to active-low seven-segment pattern. Codes 10-15 never occur in a
// valid BCD register and are shown blank.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup from digit value to segment pattern
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/dot_result_display.sv
// Shows the unsigned dot-product result on a 4-digit multiplexed 7-segment
// display. A captured result is converted to BCD by sequential double-dabble
// (one bit per clock); the display register only changes when a conversion
// finishes. Values above 9999 show dashes and raise ovf.
// Optional build macro: LEAD_ZERO_BLANK_EN blanks leading zero digits.
module dot_result_display
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int RES_W       = 18
) (
  input  logic                  clk,
  input  logic                  btnc_n,
  input  logic [RES_W-1:0]      result,
  input  logic                  result_valid,
  output logic                  busy,
  output logic                  ovf,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp
);

  localparam int CNT_W = $clog2(RES_W + 1);
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BCD_W = 24;

  state_t             state;
  logic [CNT_W-1:0]   iter_cnt;
  logic               pend_vld;
  logic [RES_W-1:0]   pend_val;
  logic [RES_W-1:0]   bin_p0;
  logic [BCD_W-1:0]   bcd_p0;
  logic [15:0]        disp;
  logic [REF_W-1:0]   ref_cnt;
  logic [1:0]         dig_idx;
  logic               done;
  logic [3:0]         cur_bcd;
  logic [6:0]         dec_seg;
  logic [3:0]         blank;

  // One double-dabble iteration: add 3 to every digit >= 5, then shift in a bit
  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] b,
                                                   input logic in_bit);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return (r << 1) | BCD_W'(in_bit);
  endfunction

  assign done = (state == CONVERT) && (iter_cnt == CNT_W'(RES_W));

  // Conversion control: state, busy, pending slot and display register
  always_ff @(posedge clk or negedge btnc_n) begin
    if (!btnc_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      iter_cnt <= '0;
      pend_vld <= 1'b0;
      ovf      <= 1'b0;
      disp     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (result_valid) begin
            state    <= CONVERT;
            busy     <= 1'b1;
            iter_cnt <= '0;
          end
        end
        CONVERT: begin
          if (done) begin
            disp <= bcd_p0[15:0];
            ovf  <= |bcd_p0[23:16];
            if (result_valid || pend_vld) begin
              iter_cnt <= '0;
              pend_vld <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
            if (result_valid) pend_vld <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Conversion datapath: operand capture, BCD shifting and pending value
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (result_valid) begin
        bin_p0 <= result;
        bcd_p0 <= '0;
      end
    end else if (done) begin
      // A strobe arriving on the completion edge is newer than the slot
      if (result_valid) begin
        bin_p0 <= result;
        bcd_p0 <= '0;
      end else if (pend_vld) begin
        bin_p0 <= pend_val;
        bcd_p0 <= '0;
      end
    end else begin
      bcd_p0 <= dabble_step(bcd_p0, bin_p0[RES_W-1]);
      bin_p0 <= bin_p0 << 1;
      if (result_valid) pend_val <= result;
    end
  end

  // Digit scan: refresh counter advances the digit index on wrap
  always_ff @(posedge clk or negedge btnc_n) begin
    if (!btnc_n) begin
      ref_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      dig_idx <= dig_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  assign cur_bcd = disp[dig_idx*4 +: 4];

  seg_decoder u_seg_decoder (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  // Leading-zero mask; the rightmost digit is always shown
  always_comb begin
    blank = 4'b0000;
`ifdef LEAD_ZERO_BLANK_EN
    blank[3] = (disp[15:12] == 4'd0);
    blank[2] = blank[3] && (disp[11:8] == 4'd0);
    blank[1] = blank[2] && (disp[7:4] == 4'd0);
`endif
  end

  // Segment/anode drive for the digit currently selected by the scan
  always_comb begin
    if (ovf)                seg = SEG_DASH;
    else if (blank[dig_idx]) seg = SEG_BLANK;
    else                    seg = dec_seg;
    an = ~(4'b0001 << dig_idx);
    dp = 1'b1;
  end

endmodule

// File: tb/tb_dot_result_display.sv
// Scoreboard bench for dot_result_display with REFRESH_DIV=4.
module tb_dot_result_display;

  localparam int RES_W = 18;
  localparam int CONV  = RES_W + 1;

  typedef struct packed {
    logic [3:0][6:0] s;
    logic            o;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [RES_W-1:0]  result;
  logic              result_valid;
  logic              busy;
  logic              ovf;
  logic [6:0]        seg;
  logic [3:0]        an;
  logic              dp;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t expq[$];

  // monitor state
  int   run = 0;
  int   total = 0;
  int   last_run = 0;
  bit   arm = 0;
  bit   scanning = 0;
  int   scan_n = 0;
  bit   an_bad = 0;
  logic ovf_s;
  logic [3:0][6:0] obs;
  bit   prev_busy = 0;

  always #5 clk = ~clk;

  dot_result_display #(.REFRESH_DIV(4), .RES_W(RES_W)) dut (
    .clk          (clk),
    .btnc_n       (rst_n),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .ovf          (ovf),
    .seg          (seg),
    .an           (an),
    .dp           (dp)
  );

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Push a hand-computed expectation; lead_blanks applies only with the blanking build
  task automatic push_exp(input int d3, input int d2, input int d1, input int d0,
                          input bit o, input int lead_blanks);
    exp_t e;
    e.o = o;
    if (o) begin
      for (int i = 0; i < 4; i++) e.s[i] = 7'b0111111;
    end else begin
      e.s[3] = pat(d3);
      e.s[2] = pat(d2);
      e.s[1] = pat(d1);
      e.s[0] = pat(d0);
`ifdef LEAD_ZERO_BLANK_EN
      for (int i = 0; i < lead_blanks; i++) e.s[3-i] = 7'b1111111;
`else
      if (lead_blanks < 0) e.s[0] = 7'b1111111;
`endif
    end
    expq.push_back(e);
  endtask

  task automatic strobe(input int v);
    @(posedge clk);
    #1 result = RES_W'(v);
    result_valid = 1'b1;
    @(posedge clk);
    #1 result_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((expq.size() != 0 || busy || scanning || arm) && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk("drain_in_time", (t < 400), 1);
  endtask

  // Release reset on a falling edge and verify the scan order of a 0000 display
  task automatic scan_release();
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      exp_an = ~(4'b0001 << (k / 4));
      exp_seg = 7'b1000000;
`ifdef LEAD_ZERO_BLANK_EN
      if (k >= 4) exp_seg = 7'b1111111;
`endif
      chk($sformatf("scan_an_k%0d", k), an, exp_an);
      chk($sformatf("scan_seg_k%0d", k), seg, exp_seg);
    end
  endtask

  // Monitor: every CONV busy cycles is one display update; scan all digits and compare
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      total = 0;
      arm = 0;
      scanning = 0;
      prev_busy = 0;
    end else begin
      if (arm) begin
        arm = 0;
        scanning = 1;
        scan_n = 0;
        an_bad = 0;
        ovf_s = ovf;
      end
      if (scanning) begin
        case (an)
          4'b1110: obs[0] = seg;
          4'b1101: obs[1] = seg;
          4'b1011: obs[2] = seg;
          4'b0111: obs[3] = seg;
          default: an_bad = 1;
        endcase
        scan_n++;
        if (scan_n == 16) begin
          scanning = 0;
          if (expq.size() == 0) begin
            chk("unexpected_update", 1, 0);
          end else begin
            exp_t e;
            e = expq.pop_front();
            chk("ovf", ovf_s, e.o);
            chk("an_onehot", an_bad, 0);
            for (int i = 0; i < 4; i++) chk($sformatf("digit%0d", i), obs[i], e.s[i]);
          end
        end
      end
      if (busy) begin
        run++;
        total++;
        if (run == CONV) begin
          run = 0;
          arm = 1;
        end
      end else if (prev_busy) begin
        chk("busy_len_multiple", run, 0);
        last_run = total;
        total = 0;
        run = 0;
      end
      prev_busy = busy;
    end
  end

  initial begin
    rst_n = 1'b0;
    result = '0;
    result_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_dp", dp, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    scan_release();

    strobe(16);
    push_exp(0, 0, 1, 6, 0, 2);
    wait_done();
    chk("busy_len_16", last_run, 19);

    strobe(260100);
    push_exp(0, 0, 0, 0, 1, 0);
    wait_done();
    strobe(9999);
    push_exp(9, 9, 9, 9, 0, 0);
    wait_done();

    strobe(10000);
    push_exp(0, 0, 0, 0, 1, 0);
    wait_done();
    strobe(0);
    push_exp(0, 0, 0, 0, 0, 3);
    wait_done();

    // back-to-back: 30 is overwritten by 42 in the pending slot
    strobe(16);
    push_exp(0, 0, 1, 6, 0, 2);
    repeat (3) @(posedge clk);
    strobe(30);
    repeat (4) @(posedge clk);
    strobe(42);
    push_exp(0, 0, 4, 2, 0, 2);
    wait_done();
    chk("busy_len_pending", last_run, 38);

    // strobe landing exactly on the completion edge
    strobe(5);
    push_exp(0, 0, 0, 5, 0, 3);
    repeat (17) @(posedge clk);
    strobe(7);
    push_exp(0, 0, 0, 7, 0, 3);
    wait_done();
    chk("busy_len_edge", last_run, 38);

    // reset in the middle of a conversion
    strobe(1234);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_an", an, 4'b1110);
    chk("midrst_seg", seg, 7'b1000000);
    repeat (2) @(posedge clk);
    scan_release();
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ovf", ovf, 0);
    chk("post_rst_queue", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dot_result_display.md
DOT_RESULT_DISPLAY -- requirements
Module: dot_result_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit (1 kHz digit rate at 100 MHz; benches use 4).
REQ-002 SHALL have parameter RES_W, default 18, result width (4 x 255 x 255 = 260100 fits).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port btnc_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port result, input, RES_W, unsigned dot-product value from dot_product.
REQ-006 SHALL have port result_valid, input, 1, one-cycle strobe qualifying result.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port ovf, output, 1, high when the displayed value exceeds 9999.
REQ-009 SHALL have port seg, output, 7, active-low segments, seg[0]=a through seg[6]=g.
REQ-010 SHALL have port an, output, 4, active-low one-hot anodes, an[0]=rightmost digit.
REQ-011 SHALL have port dp, output, 1, active-low decimal point, tied 1 (off).

Function
REQ-012 SHALL use FSM states IDLE and CONVERT; IDLE->CONVERT on result_valid, capturing result at that edge (edge N).
REQ-013 SHALL in CONVERT run sequential double-dabble: RES_W shift iterations into a 24-bit (6-digit) BCD register, add-3 on any digit >=5 before each shift.
REQ-014 SHALL load the 4-digit display register and ovf at edge N+RES_W+1 (19 for default), then return to IDLE.
REQ-015 SHALL drive busy=1 from edge N through edge N+RES_W+1, i.e. exactly RES_W+1 cycles.
REQ-016 SHALL, when captured value >9999, set ovf=1 and show dash (g only, seg=7'b0111111) on all four digits; otherwise ovf=0 and show the four low BCD digits.
REQ-017 SHALL hold a one-deep pending slot: result_valid during CONVERT stores result there; a later strobe overwrites it; on completion a pending value starts a new conversion on the next edge with no IDLE cycle.
REQ-018 SHALL treat result_valid on the completion edge as pending (not dropped).
REQ-019 SHALL keep the display register unchanged during CONVERT (no partial values shown).
REQ-020 SHALL scan with a refresh counter 0..REFRESH_DIV-1; on wrap the digit index advances 0->1->2->3->0.
REQ-021 SHALL drive an low only for the current index and seg with that digit's pattern in the same cycle.
REQ-022 SHALL encode decimal 0-9 with standard active-low patterns (0 = 7'b1000000, 1 = 7'b1111001).

Reset
REQ-023 SHALL on btnc_n low immediately force IDLE, busy=0, ovf=0, pending cleared, refresh counter and digit index 0, display register 0000.
REQ-024 SHALL present an=4'b1110, seg=7'b1000000, dp=1 during and after reset.
REQ-025 SHALL abort an in-progress conversion on reset with no display update afterward.

Configuration
REQ-026 SHALL with LEAD_ZERO_BLANK_EN defined blank (seg=7'b1111111) every digit above the most significant nonzero digit; digit 0 is never blanked; dash display is unaffected.
REQ-027 SHALL without LEAD_ZERO_BLANK_EN show all four digits including leading zeros.

Structure
REQ-028 SHALL place in shared package seg_pkg: state typedef, NUM_DIGITS=4, SEG_DASH, SEG_BLANK, and digit pattern constants.
REQ-029 SHALL instantiate one sub-module seg_decoder (4-bit BCD in, 7-bit active-low pattern out); everything else stays in dot_result_display.

Verification
REQ-030 SHALL cover: reset asserted mid-run -> an=4'b1110, seg=7'b1000000, busy=0, ovf=0.
REQ-031 SHALL cover: result=16 strobe (A=B=2,2,2,2) -> busy high 19 cycles, then digits 0,0,1,6 (blanked "  16" with macro), ovf=0.
REQ-032 SHALL cover: result=260100 (all 8'hFF) -> ovf=1, all digits 7'b0111111; then result=9999 -> ovf=0, "9999".
REQ-033 SHALL cover: result=10000 -> ovf=1; result=0 -> "0000", or "   0" with macro.
REQ-034 SHALL cover: strobe 16, then 30 and 42 during CONVERT -> busy high 38 contiguous cycles, 16 shown, then 42 final; 30 never shown.
REQ-035 SHALL cover: REFRESH_DIV=4 -> an sequence 1110,1101,1011,0111 changing every 4 cycles, each paired with the matching digit's seg.
